// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the M-stage load/store interface.
// Optional write trace: define DM_WRITE_LOG_EN.
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [3:0]     be_q, be_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    pc_q, pc_d;
  logic           req_ready_q, req_ready_d;
  logic           resp_valid_q, resp_valid_d;
  logic [31:0]    resp_rdata_q, resp_rdata_d;

  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           commit_s;
  logic           c_we_s;
  logic [3:0]     c_be_s;
  logic [AW-1:0]  c_idx_s;
  logic [31:0]    c_wdata_s;
  logic [31:0]    c_pc_s;
  logic [31:0]    old_word_s;
  logic [31:0]    merged_s;
  logic           mem_we_s;
  logic           unused_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Next-state, request latching and commit datapath.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    be_d         = be_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    pc_d         = pc_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    commit_s     = 1'b0;
    c_we_s       = we_q;
    c_be_s       = be_q;
    c_idx_s      = idx_q;
    c_wdata_s    = wdata_q;
    c_pc_s       = pc_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          be_d        = req_be;
          idx_d       = req_addr[AW+1:2];
          wdata_d     = req_wdata;
          pc_d        = req_pc;
          cnt_d       = 4'(LATENCY - 1);
          req_ready_d = 1'b0;
          // With single-cycle latency the accepting edge is also the commit edge.
          if (LATENCY == 1) begin
            state_d      = RESP;
            commit_s     = 1'b1;
            resp_valid_d = 1'b1;
            c_we_s       = req_we;
            c_be_s       = req_be;
            c_idx_s      = req_addr[AW+1:2];
            c_wdata_s    = req_wdata;
            c_pc_s       = req_pc;
          end else begin
            state_d = BUSY;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d      = RESP;
          commit_s     = 1'b1;
          resp_valid_d = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase

    old_word_s = mem_q[c_idx_s];
    merged_s   = merge_bytes(old_word_s, c_wdata_s, c_be_s);
    mem_we_s   = commit_s & c_we_s & (|c_be_s);
    if (commit_s) begin
      resp_rdata_d = c_we_s ? merged_s : old_word_s;
    end else begin
      resp_rdata_d = resp_rdata_q;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      be_q         <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      pc_q         <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      be_q         <= be_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      pc_q         <= pc_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Word storage; cleared by reset so a discarded store leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (mem_we_s) begin
      mem_q[c_idx_s] <= merged_s;
    end
  end

`ifdef DM_WRITE_LOG_EN
  // Grader-format trace of every effective store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_s) begin
      $display("%d@%h: *%h <= %h", $time, c_pc_s, 32'({c_idx_s, 2'b00}), merged_s);
    end
  end
`endif

  assign unused_s = ^{c_pc_s, req_addr[31:AW+2], req_addr[1:0]};

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed scoreboard bench for dm_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_dm_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] req_pc = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Drive a request at a negedge, push its expected response, wait for accept.
  task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output int acc_cyc);
    int idx;
    logic [31:0] e;
    idx = int'(addr[11:2]);
    if (we) begin
      e = merge(model[idx], wdata, be);
      model[idx] = e;
    end else begin
      e = model[idx];
    end
    exp_q.push_back(e);
    req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    req_pc = 32'h0040_0000 + addr;
    req_valid = 1'b1;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response, optionally check latency, then consume and compare.
  task automatic recv(input string tag, input logic chk_lat, input int acc_cyc);
    logic [31:0] e;
    for (int k = 0; k < 20 && !resp_valid; k++) begin
      chk("busy_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    if (chk_lat) chk("latency", 32'(cyc - acc_cyc), 32'(LAT));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    chk(tag, resp_rdata, e);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
    chk("valid_after_resp", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int a;
    logic [31:0] held;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;

    #1 reset = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Load from fresh memory with latency measurement.
    send(1'b0, 4'hF, 32'h0000_0010, 32'd0, a);
    recv("load_0x10", 1'b1, a);
    chk("load_0x10_const", resp_rdata, 32'd0);

    // Full-word store then load back.
    send(1'b1, 4'hF, 32'h0000_0004, 32'h1234_5678, a);
    recv("store_0x4", 1'b1, a);
    send(1'b0, 4'h0, 32'h0000_0004, 32'd0, a);
    recv("load_0x4", 1'b1, a);
    chk("load_0x4_const", resp_rdata, 32'h1234_5678);

    // Partial byte-enable merge.
    send(1'b1, 4'hF, 32'h0000_0008, 32'h1122_3344, a);
    recv("store_0x8", 1'b0, a);
    send(1'b1, 4'b0101, 32'h0000_0008, 32'hAABB_CCDD, a);
    recv("store_be0101", 1'b0, a);
    chk("store_be0101_const", resp_rdata, 32'h11BB_33DD);
    send(1'b0, 4'hF, 32'h0000_000A, 32'd0, a);
    recv("load_merged", 1'b0, a);
    chk("load_merged_const", resp_rdata, 32'h11BB_33DD);

    // Store with no byte enables returns and keeps the old word.
    send(1'b1, 4'b0000, 32'h0000_0008, 32'hFFFF_FFFF, a);
    recv("store_be0", 1'b0, a);
    send(1'b0, 4'hF, 32'h0000_0008, 32'd0, a);
    recv("load_after_be0", 1'b0, a);
    chk("load_after_be0_const", resp_rdata, 32'h11BB_33DD);

    // Backpressure: hold resp_ready low while toggling req_valid.
    send(1'b0, 4'hF, 32'h0000_0004, 32'd0, a);
    for (int k = 0; k < 20 && !resp_valid; k++) @(negedge clk);
    held = resp_rdata;
    req_we = 1'b1; req_addr = 32'h0000_0004; req_wdata = 32'hDEAD_DEAD; req_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      req_valid = k[0] ? 1'b0 : 1'b1;
      @(negedge clk);
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, held);
      chk("stall_no_accept", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    recv("stall_load", 1'b0, a);
    send(1'b0, 4'hF, 32'h0000_0004, 32'd0, a);
    recv("no_stray_store", 1'b0, a);

    // Address wrap modulo 1024 words.
    send(1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, a);
    recv("store_wrap", 1'b0, a);
    send(1'b0, 4'hF, 32'h0000_0000, 32'd0, a);
    recv("load_wrap", 1'b0, a);
    chk("load_wrap_const", resp_rdata, 32'hCAFE_F00D);

    // Reset while BUSY discards the store and clears memory.
    send(1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, a);
    chk("busy_before_reset", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(1'b0, 4'hF, 32'h0000_0020, 32'd0, a);
    recv("load_after_reset", 1'b1, a);
    send(1'b0, 4'hF, 32'h0000_0004, 32'd0, a);
    recv("mem_cleared", 1'b0, a);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
